div_16b: RTL and testbench
==========================

DIV_16B -- requirements
Module: div_16b

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start  input  1  request a divide; sampled only in IDLE.
REQ-004 SHALL have port: signed_op  input  1  1 = two's-complement divide, 0 = unsigned divide.
REQ-005 SHALL have port: dividend  input  16  numerator; sampled with start.
REQ-006 SHALL have port: divisor  input  16  denominator; sampled with start.
REQ-007 SHALL have port: busy  output  1  high while an operation is in progress (RUN or FIX).
REQ-008 SHALL have port: done  output  1  one-cycle pulse; results valid in that cycle.
REQ-009 SHALL have port: quotient  output  16  result quotient.
REQ-010 SHALL have port: remainder  output  16  result remainder.
REQ-011 SHALL have port: div_by_zero  output  1  flag set when the last accepted divisor was 0.

Function
REQ-012 SHALL implement states IDLE, RUN, FIX, DONE.
- IDLE->RUN: start=1 and divisor!=0.
- IDLE->DONE: start=1 and divisor=0.
- RUN->FIX: after exactly 16 RUN cycles.
- FIX->IDLE: unconditional.
- DONE->IDLE: unconditional.
REQ-013 SHALL, when start is accepted at edge T with divisor!=0, occupy RUN for cycles T+1..T+16 and FIX at T+17, and assert done during cycle T+18.
REQ-014 SHALL use restoring shift-subtract division, one quotient bit per RUN cycle, MSB first, on the 16-bit magnitudes of the operands.
- The partial remainder is 17 bits wide.
REQ-015 SHALL, when signed_op=1, divide the absolute values and negate the results in FIX:
- quotient is negated when the operand signs differ;
- remainder is negated when the dividend is negative;
- the quotient truncates toward zero.
REQ-016 SHALL, for signed 16'h8000 / 16'hFFFF, return quotient 16'h8000 and remainder 16'h0000 (wrap, no flag).
REQ-017 SHALL, on a zero divisor, return quotient 16'hFFFF, remainder = dividend and div_by_zero=1, with done asserted in cycle T+1.
REQ-018 SHALL clear div_by_zero on the next accepted start whose divisor is nonzero.
REQ-019 SHALL ignore start while busy=1 or done=1; the in-flight operation SHALL complete unaffected.
REQ-020 SHALL hold quotient, remainder and div_by_zero stable from done until the next accepted start.
- The contents of quotient and remainder between an accepted start and its done are unspecified.
REQ-021 SHALL hold busy=1 exactly in RUN and FIX; done=1 exactly in DONE.
REQ-022 SHALL NOT accept a start in the same cycle that done is high; the earliest next start is sampled in the cycle after done.

Reset
REQ-023 SHALL, on rst_n low, immediately force state IDLE and set busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and the iteration counter to 0.
REQ-024 SHALL abandon any in-flight operation on reset with no done pulse; operation resumes on the first rising clk edge after rst_n rises.

Structure
REQ-025 SHALL take the state encodings (2-bit) and the DIV_ITER=16 constant from a shared package, so that pipeline control can reference them.
REQ-026 SHALL place one iteration (17-bit compare/subtract, quotient-bit generation) in a sub-module div_step; the counter, FSM and sign fix-up stay in div_16b.

Verification
REQ-027 Unsigned 100/7, start at T -> busy T+1..T+17, done at T+18, quotient=14, remainder=2, div_by_zero=0.
REQ-028 Signed 16'hFFF9 (-7) / 2 -> quotient 16'hFFFD (-3), remainder 16'hFFFF (-1); signed 7 / 16'hFFFE -> quotient 16'hFFFD, remainder 1.
REQ-029 Zero divisor 16'h04D2 / 0 -> done at T+1, quotient 16'hFFFF, remainder 16'h04D2, div_by_zero=1; then 10/3 -> 3, 1, div_by_zero=0.
REQ-030 Signed 16'h8000 / 16'hFFFF -> 16'h8000, 0; unsigned 16'hFFFF / 1 -> 16'hFFFF, 0.
REQ-031 Start pulsed at T+5 during an active 50/5 -> ignored; single done at T+18 with 10, 0.
REQ-032 Reset at T+7 mid-RUN -> all outputs 0, no done; new start after release completes normally.

Source files
------------

// File: rtl/div_16b_pkg.sv
// Shared constants for the 16-bit iterative divider: FSM encodings, iteration
// count and a two's-complement helper used for operand/result sign handling.
package div_16b_pkg;

    localparam int unsigned DIV_ITER = 16;
    localparam int unsigned CNT_W    = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Conditionally negate a 16-bit value (two's complement, wraps on 16'h8000).
    function automatic logic [15:0] cond_neg16(input logic [15:0] v, input logic neg);
        return neg ? (~v + 16'd1) : v;
    endfunction

endpackage

// File: rtl/div_16b_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract the divisor, keep the difference only when it does not underflow.
module div_step (
    input  logic [16:0] i_rem,
    input  logic        i_dvd_bit,
    input  logic [15:0] i_divisor,
    output logic [16:0] o_rem,
    output logic        o_q_bit
);

    logic [16:0] w_shifted;
    logic [17:0] w_diff;

    assign w_shifted = {i_rem[15:0], i_dvd_bit};
    // Extra bit catches the borrow, which means the trial subtraction failed.
    assign w_diff    = {1'b0, w_shifted} - {2'b00, i_divisor};

    // Restore the shifted remainder when the trial subtraction borrows.
    always_comb begin
        o_q_bit = ~w_diff[17];
        o_rem   = w_diff[17] ? w_shifted : w_diff[16:0];
    end

endmodule

// File: rtl/div_16b.sv
// 16-bit signed/unsigned restoring divider: 16 RUN cycles (one quotient bit
// each, MSB first), a FIX cycle for sign correction, then a one-cycle DONE.
module div_16b
    import div_16b_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        signed_op,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero
);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [16:0]      r_rem;
    logic [15:0]      r_acc;      // dividend bits shift out MSB-first, quotient bits shift in
    logic [15:0]      r_dvs;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [15:0]      r_quotient;
    logic [15:0]      r_remainder;
    logic             r_dbz;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [15:0]      w_a_mag;
    logic [15:0]      w_b_mag;
    logic [16:0]      w_step_rem;
    logic             w_step_q;

    assign w_a_neg = signed_op & dividend[15];
    assign w_b_neg = signed_op & divisor[15];
    assign w_a_mag = cond_neg16(dividend, w_a_neg);
    assign w_b_mag = cond_neg16(divisor, w_b_neg);

    div_step u_step (
        .i_rem     (r_rem),
        .i_dvd_bit (r_acc[15]),
        .i_divisor (r_dvs),
        .o_rem     (w_step_rem),
        .o_q_bit   (w_step_q)
    );

    // FSM, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_acc       <= '0;
            r_dvs       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (divisor == 16'd0) begin
                            r_quotient  <= 16'hFFFF;
                            r_remainder <= dividend;
                            r_dbz       <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_dbz   <= 1'b0;
                            r_rem   <= '0;
                            r_acc   <= w_a_mag;
                            r_dvs   <= w_b_mag;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                            r_cnt   <= '0;
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    r_rem <= w_step_rem;
                    r_acc <= {r_acc[14:0], w_step_q};
                    if (r_cnt == CNT_W'(DIV_ITER - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_FIX;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_FIX: begin
                    r_quotient  <= cond_neg16(r_acc, r_neg_q);
                    r_remainder <= cond_neg16(r_rem[15:0], r_neg_r);
                    r_state     <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status outputs decode directly from the state register.
    always_comb begin
        busy = (r_state == ST_RUN) || (r_state == ST_FIX);
        done = (r_state == ST_DONE);
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_16b.sv
// Directed self-checking bench for div_16b: latency, signed/unsigned results,
// zero divisor, overflow wrap, ignored start while busy, and mid-run reset.
module tb_div_16b;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        signed_op;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int checks;
    int failures;

    div_16b u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one divide and check latency, results and the single done pulse.
    // inject_at > 0 pulses an extra start (zero divisor) in that cycle after T.
    task automatic run_op(input string tag, input logic sgn, input logic [15:0] a,
                          input logic [15:0] b, input int exp_lat, input logic [15:0] eq,
                          input logic [15:0] er, input logic edbz, input int inject_at);
        int n;
        @(negedge clk);
        signed_op = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n     = 1;
        if (exp_lat > 1) chk({tag, " busy@T+1"}, 32'(busy), 32'd1);
        while (done !== 1'b1 && n < 40) begin
            if (n == inject_at) begin
                start    = 1'b1;
                dividend = 16'h0063;
                divisor  = 16'h0000;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk({tag, " latency"}, 32'(n), 32'(exp_lat));
        chk({tag, " quotient"}, 32'(quotient), 32'(eq));
        chk({tag, " remainder"}, 32'(remainder), 32'(er));
        chk({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edbz));
        chk({tag, " busy@done"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, " done_single"}, 32'(done), 32'd0);
        chk({tag, " quotient_held"}, 32'(quotient), 32'(eq));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;

        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset quotient", 32'(quotient), 32'd0);
        chk("reset remainder", 32'(remainder), 32'd0);
        chk("reset div_by_zero", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;

        run_op("u100/7", 1'b0, 16'd100, 16'd7, 18, 16'd14, 16'd2, 1'b0, 0);
        run_op("s-7/2", 1'b1, 16'hFFF9, 16'd2, 18, 16'hFFFD, 16'hFFFF, 1'b0, 0);
        run_op("uFFF9/2", 1'b0, 16'hFFF9, 16'd2, 18, 16'h7FFC, 16'd1, 1'b0, 0);
        run_op("s7/-2", 1'b1, 16'd7, 16'hFFFE, 18, 16'hFFFD, 16'd1, 1'b0, 0);
        run_op("div0", 1'b0, 16'h04D2, 16'h0000, 1, 16'hFFFF, 16'h04D2, 1'b1, 0);
        run_op("u10/3", 1'b0, 16'd10, 16'd3, 18, 16'd3, 16'd1, 1'b0, 0);
        run_op("s8000/-1", 1'b1, 16'h8000, 16'hFFFF, 18, 16'h8000, 16'h0000, 1'b0, 0);
        run_op("uFFFF/1", 1'b0, 16'hFFFF, 16'd1, 18, 16'hFFFF, 16'h0000, 1'b0, 0);
        run_op("u50/5 ignore", 1'b0, 16'd50, 16'd5, 18, 16'd10, 16'd0, 1'b0, 5);

        // Mid-run reset: start at T, assert rst_n during cycle T+7.
        @(negedge clk);
        signed_op = 1'b0;
        dividend  = 16'd50;
        divisor   = 16'd5;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre-reset busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        chk("midrst quotient", 32'(quotient), 32'd0);
        chk("midrst remainder", 32'(remainder), 32'd0);
        chk("midrst div_by_zero", 32'(div_by_zero), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        run_op("post-reset s-100/7", 1'b1, 16'hFF9C, 16'd7, 18, 16'hFFF2, 16'hFFFE, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
